output_drain_rr: RTL and testbench

//  Reader side of the 4x4 switch's output FIFOs (FIFO 4..7). Round-robin

---
 rtl/output_drain_rr.sv | 141 ++++++++++++++
 tb/tb_output_drain_rr.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_rr.sv
// Reader side of the switch output FIFOs: round-robin pops one non-empty
// FIFO at a time, forwards the word on a valid/ready stream tagged with its
// port, flags the first destination mismatch and keeps saturating per-port
// word counts.
module output_drain_rr #(
    parameter int data_width = 10,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            empty_out,
    input  logic [data_width-1:0] data_in0,
    input  logic [data_width-1:0] data_in1,
    input  logic [data_width-1:0] data_in2,
    input  logic [data_width-1:0] data_in3,
    output logic [3:0]            pop,
    output logic [data_width-1:0] out_data,
    output logic [1:0]            out_port,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_dest,
    output logic [1:0]            err_port,
    output logic [cnt_width-1:0]  cnt0,
    output logic [cnt_width-1:0]  cnt1,
    output logic [cnt_width-1:0]  cnt2,
    output logic [cnt_width-1:0]  cnt3
);

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

    state_t                state;
    state_t                next_state;
    logic [1:0]            last_grant;
    logic [1:0]            next_grant;
    logic [1:0]            idx;
    logic                  have_cand;
    logic                  do_pop;
    logic [data_width-1:0] sel_data;
    logic [cnt_width-1:0]  cnt [4];

    // Search the ports starting just after the last grant; first non-empty wins.
    always_comb begin
        have_cand  = 1'b0;
        next_grant = last_grant;
        idx        = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!have_cand && !empty_out[idx]) begin
                have_cand  = 1'b1;
                next_grant = idx;
            end
        end
    end

    // Next-state and pop decision; a pop may overlap the accepting SEND cycle.
    always_comb begin
        next_state = state;
        do_pop     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && have_cand) begin
                    do_pop     = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: next_state = SEND;
            SEND: begin
                if (out_ready) begin
                    if (enable && have_cand) begin
                        do_pop     = 1'b1;
                        next_state = CAPTURE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign pop = do_pop ? (4'b0001 << next_grant) : 4'b0000;

    // The granted FIFO's output, read one cycle after its pop.
    always_comb begin
        case (last_grant)
            2'd0:    sel_data = data_in0;
            2'd1:    sel_data = data_in1;
            2'd2:    sel_data = data_in2;
            default: sel_data = data_in3;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Grant pointer; starts at 3 so the first grant goes to port 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      last_grant <= 2'd3;
        else if (do_pop) last_grant <= next_grant;
    end

    // Output word register and sticky destination-error capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_port  <= '0;
            out_valid <= 1'b0;
            err_dest  <= 1'b0;
            err_port  <= '0;
        end else if (state == CAPTURE) begin
            out_data  <= sel_data;
            out_port  <= last_grant;
            out_valid <= 1'b1;
            if ((sel_data[1:0] != last_grant) && !err_dest) begin
                err_dest <= 1'b1;
                err_port <= last_grant;
            end
        end else if (state == SEND && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-port accepted-word counters that stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (state == SEND && out_ready && (cnt[out_port] != '1)) begin
            cnt[out_port] <= cnt[out_port] + cnt_width'(1);
        end
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];

endmodule

// File: tb/tb_output_drain_rr.sv
// Scoreboard bench for output_drain_rr: behavioural FIFOs feed the DUT,
// expected words are queued per port when pushed, and a negedge monitor
// checks grants, forwarded words, counters and error flags.
module tb_output_drain_rr;

    localparam int DW      = 10;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [3:0]    empty_out;
    logic [DW-1:0] data_r [4];
    logic [3:0]    pop;
    logic [DW-1:0] out_data;
    logic [1:0]    out_port;
    logic          out_valid;
    logic          out_ready;
    logic          err_dest;
    logic [1:0]    err_port;
    logic [CW-1:0] cnt_w [4];

    logic [DW-1:0] fifo_q [4][$];
    logic [DW-1:0] exp_q  [4][$];
    int            pop_log [$];

    int            checks;
    int            failures;
    logic [3:0]    pop_seen;
    logic [3:0]    prev_pop;
    bit            stall_prev;
    logic [DW-1:0] held_data;
    logic [1:0]    held_port;
    int            model_last;
    int            model_cnt [4];
    bit            model_err;
    int            model_err_port;
    logic [7:0]    seq;

    output_drain_rr #(.data_width(DW), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty_out(empty_out),
        .data_in0(data_r[0]), .data_in1(data_r[1]), .data_in2(data_r[2]), .data_in3(data_r[3]),
        .pop(pop), .out_data(out_data), .out_port(out_port), .out_valid(out_valid),
        .out_ready(out_ready), .err_dest(err_dest), .err_port(err_port),
        .cnt0(cnt_w[0]), .cnt1(cnt_w[1]), .cnt2(cnt_w[2]), .cnt3(cnt_w[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] emp);
        for (int k = 1; k <= 4; k++) begin
            if (!emp[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < 4; i++)
            if (fifo_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic update_empty();
        for (int i = 0; i < 4; i++) empty_out[i] = (fifo_q[i].size() == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input int p, input logic [DW-1:0] w);
        fifo_q[p].push_back(w);
        exp_q[p].push_back(w);
        update_empty();
    endtask

    function automatic logic [DW-1:0] mk_word(input int p, input bit good);
        logic [1:0] d;
        d = good ? 2'(p) : 2'(p + 1);
        seq = seq + 8'd1;
        return {seq, d};
    endfunction

    task automatic flush_all();
        for (int i = 0; i < 4; i++) begin
            fifo_q[i].delete();
            exp_q[i].delete();
        end
        update_empty();
    endtask

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        enable = 1'b1;
        while (busy() && n < 3000) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        checks++;
        if (busy()) begin
            failures++;
            $display("[TB] FAIL drain_timeout actual=busy expected=idle");
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_output("wait_valid", out_valid, 1);
    endtask

    // Behavioural output FIFOs: a pop seen during a cycle delivers the head word after that edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++)
            if (reset && pop_seen[i] && fifo_q[i].size() > 0) data_r[i] = fifo_q[i].pop_front();
        update_empty();
    end

    // Monitor: grant order, stability under backpressure, scoreboard, counters, errors.
    always @(negedge clk) begin
        int g;
        int p;
        logic [DW-1:0] w;
        pop_seen = pop;
        if (!reset) begin
            prev_pop       = '0;
            stall_prev     = 1'b0;
            model_last     = 3;
            model_err      = 1'b0;
            model_err_port = 0;
            for (int i = 0; i < 4; i++) model_cnt[i] = 0;
        end else begin
            if (pop != 4'b0000) begin
                g = rr_pick(model_last, empty_out);
                check_output("pop_grant", pop, (g < 0) ? 4'b0000 : (4'b0001 << g));
                check_output("pop_enable", enable, 1);
                check_output("pop_back_to_back", prev_pop, 0);
                if (g >= 0) begin
                    model_last = g;
                    pop_log.push_back(g);
                end
            end
            if (stall_prev) begin
                check_output("hold_valid", out_valid, 1);
                check_output("hold_data", out_data, held_data);
                check_output("hold_port", out_port, held_port);
            end
            for (int i = 0; i < 4; i++)
                check_output($sformatf("cnt%0d", i), cnt_w[i], model_cnt[i]);
            if (out_valid && out_ready) begin
                p = out_port;
                checks++;
                if (exp_q[p].size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_word actual=%0h expected=none port=%0d", out_data, p);
                end else begin
                    w = exp_q[p].pop_front();
                    check_output("out_data", out_data, w);
                    if (w[1:0] != 2'(p) && !model_err) begin
                        model_err      = 1'b1;
                        model_err_port = p;
                    end
                end
                check_output("err_dest", err_dest, model_err);
                if (model_err) check_output("err_port", err_port, model_err_port);
                if (model_cnt[p] < CNT_MAX) model_cnt[p]++;
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_port  = out_port;
            prev_pop   = pop;
        end
    end

    initial begin
        int rr_exp [5];
        int log_start;
        logic [DW-1:0] held;
        rr_exp = '{0, 1, 2, 3, 0};
        checks = 0;
        failures = 0;
        seq = 8'd0;
        pop_seen = '0;
        reset = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) data_r[i] = '0;
        update_empty();
        repeat (3) tick();
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_pop", pop, 0);
        check_output("reset_out_data", out_data, 0);
        check_output("reset_err", err_dest, 0);
        reset = 1'b1;
        enable = 1'b1;
        tick();

        // Single word from port 0 with two-cycle latency to out_valid.
        out_ready = 1'b1;
        apply_stimulus(0, 10'h004);
        #1;
        check_output("single_pop", pop, 4'b0001);
        tick();
        check_output("single_capture_pop", pop, 0);
        check_output("single_capture_valid", out_valid, 0);
        tick();
        check_output("single_valid", out_valid, 1);
        check_output("single_data", out_data, 10'h004);
        check_output("single_port", out_port, 0);
        tick();
        check_output("single_cnt0", cnt_w[0], 1);
        check_output("single_done_valid", out_valid, 0);

        // Backpressure: word held stable, no pop, no count until release.
        out_ready = 1'b0;
        apply_stimulus(1, mk_word(1, 1));
        apply_stimulus(2, mk_word(2, 1));
        wait_valid();
        check_output("bp_port", out_port, 1);
        held = out_data;
        repeat (5) begin
            tick();
            check_output("bp_data_stable", out_data, held);
            check_output("bp_pop", pop, 0);
            check_output("bp_cnt1", cnt_w[1], 0);
        end
        out_ready = 1'b1;
        tick();
        check_output("bp_release_cnt1", cnt_w[1], 1);

        // Saturation: five more words on port 1 saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) apply_stimulus(1, mk_word(1, 1));
        drain(0);
        check_output("sat_cnt1", cnt_w[1], 3);

        // Destination errors: first mismatch on port 2 sticks.
        apply_stimulus(2, 10'h001);
        drain(0);
        check_output("dest_err", err_dest, 1);
        check_output("dest_err_port", err_port, 2);
        check_output("dest_cnt2", cnt_w[2], 2);
        apply_stimulus(3, 10'h002);
        drain(0);
        check_output("dest_err_port_kept", err_port, 2);
        check_output("dest_cnt3", cnt_w[3], 1);

        // enable low blocks all pops.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(i, mk_word(i, 1));
        repeat (8) begin
            tick();
            check_output("enable_low_pop", pop, 0);
        end
        drain(0);

        // Reset in the middle of SEND.
        out_ready = 1'b0;
        apply_stimulus(0, mk_word(0, 1));
        wait_valid();
        reset = 1'b0;
        flush_all();
        #1;
        check_output("rst_mid_valid", out_valid, 0);
        check_output("rst_mid_pop", pop, 0);
        check_output("rst_mid_cnt1", cnt_w[1], 0);
        check_output("rst_mid_err", err_dest, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Round robin from a fresh reset with all ports loaded.
        out_ready = 1'b1;
        log_start = pop_log.size();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i, mk_word(i, 1));
            apply_stimulus(i, mk_word(i, 1));
        end
        drain(0);
        checks++;
        if (pop_log.size() < log_start + 5) begin
            failures++;
            $display("[TB] FAIL rr_pop_count actual=%0d expected=%0d", pop_log.size() - log_start, 8);
        end else begin
            for (int k = 0; k < 5; k++)
                check_output($sformatf("rr_order%0d", k), pop_log[log_start + k], rr_exp[k]);
        end

        // Randomized traffic with random enable and backpressure.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, 3);
                apply_stimulus(p, mk_word(p, $urandom_range(0, 9) != 0));
            end
            enable = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(1);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
